// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver; 2-FF synchronized rx, start-bit validation at mid-bit,
// mid-bit data/stop sampling on the oversample tick, registered done/error strobes.
module uart_rx #(
   parameter int DATA_BITS  = 8,
   parameter int OVERSAMPLE = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 b_tick,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_done,
   output logic                 rx_busy,
   output logic                 frame_err
);
   localparam int TW = $clog2(OVERSAMPLE);
   localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
   localparam logic [TW-1:0] HALF = TW'(OVERSAMPLE / 2 - 1);
   localparam logic [TW-1:0] FULL = TW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0] LAST = BW'(DATA_BITS - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t               state_q, state_d;
   logic [TW-1:0]        tick_q, tick_d;
   logic [BW-1:0]        bit_q, bit_d;
   logic [DATA_BITS-1:0] shift_q, shift_d, data_q, data_d;
   logic                 meta_q, rx_s_q;
   logic                 done_q, done_d, ferr_q, ferr_d, busy_q, busy_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta_q  <= 1'b1;
         rx_s_q  <= 1'b1;
         state_q <= IDLE;
         tick_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         data_q  <= '0;
         done_q  <= 1'b0;
         ferr_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         meta_q  <= rx;
         rx_s_q  <= meta_q;
         state_q <= state_d;
         tick_q  <= tick_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         data_q  <= data_d;
         done_q  <= done_d;
         ferr_q  <= ferr_d;
         busy_q  <= busy_d;
      end
   end

   always_comb begin
      state_d = state_q;
      tick_d  = tick_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      data_d  = data_q;
      done_d  = 1'b0;
      ferr_d  = 1'b0;
      if (b_tick) begin
         case (state_q)
            IDLE: begin
               if (!rx_s_q) begin
                  state_d = START;
                  tick_d  = '0;
               end
            end
            START: begin
               if (tick_q == HALF) begin
                  state_d = rx_s_q ? IDLE : DATA;
                  tick_d  = '0;
                  bit_d   = '0;
               end else tick_d = tick_q + 1'b1;
            end
            DATA: begin
               if (tick_q == FULL) begin
                  tick_d  = '0;
                  shift_d = DATA_BITS'({rx_s_q, shift_q} >> 1);
                  state_d = (bit_q == LAST) ? STOP : DATA;
                  bit_d   = (bit_q == LAST) ? bit_q : bit_q + 1'b1;
               end else tick_d = tick_q + 1'b1;
            end
            STOP: begin
               // Leave at mid-stop-bit so a back-to-back start edge is not missed
               if (tick_q == FULL) begin
                  state_d = IDLE;
                  tick_d  = '0;
                  data_d  = rx_s_q ? shift_q : data_q;
                  done_d  = rx_s_q;
                  ferr_d  = !rx_s_q;
               end else tick_d = tick_q + 1'b1;
            end
         endcase
      end
      busy_d = (state_d != IDLE);
   end

   assign rx_data   = data_q;
   assign rx_done   = done_q;
   assign rx_busy   = busy_q;
   assign frame_err = ferr_q;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames at 256 clk/bit with b_tick every 16 clk; strobes are
// collected by a monitor and checked per scenario.
module tb_uart_rx;
   logic       clk = 1'b0, rst = 1'b1, b_tick = 1'b0, rx = 1'b1;
   logic [7:0] rx_data;
   logic       rx_done, rx_busy, frame_err;
   int         errors = 0, checks = 0;
   bit         tick_en = 1'b1;
   int         tc = 0, ferr_n = 0, both_n = 0, fz_n = 0;
   logic       fz_busy = 1'b0;
   logic [7:0] got[$];

   uart_rx dut (
      .clk(clk), .rst(rst), .b_tick(b_tick), .rx(rx),
      .rx_data(rx_data), .rx_done(rx_done), .rx_busy(rx_busy), .frame_err(frame_err)
   );

   always #5 clk = ~clk;

   initial forever begin
      @(negedge clk);
      if (tick_en) begin
         tc = (tc + 1) % 16;
         b_tick = (tc == 0);
      end else b_tick = 1'b0;
   end

   initial forever begin
      @(negedge clk);
      if (rx_done) got.push_back(rx_data);
      if (frame_err) ferr_n++;
      if (rx_done && frame_err) both_n++;
   end

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop, input int pause_bit);
      rx = 1'b0;
      wait_clk(256);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         if (i == pause_bit) begin
            wait_clk(128);
            tick_en = 1'b0;
            wait_clk(1000);
            fz_busy = rx_busy;
            fz_n = got.size();
            tick_en = 1'b1;
            wait_clk(128);
         end else wait_clk(256);
      end
      rx = stop;
      wait_clk(256);
      rx = 1'b1;
   endtask

   task automatic test_reset;
      wait_clk(3);
      rst = 1'b0;
      wait_clk(20);
      checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", rx_data); end
      checks++; if (rx_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", rx_done); end
      checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", rx_busy); end
      checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr: got %b want 0", frame_err); end
   endtask

   task automatic test_single;
      got.delete(); ferr_n = 0;
      send_frame(8'h55, 1'b1, -1);
      wait_clk(64);
      checks++; if (got.size() != 1) begin errors++; $display("FAIL single_count: got %0d want 1", got.size()); end
      checks++; if (rx_data !== 8'h55) begin errors++; $display("FAIL single_data: got %h want 55", rx_data); end
      checks++; if (ferr_n != 0) begin errors++; $display("FAIL single_ferr: got %0d want 0", ferr_n); end
      checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL single_busy: got %b want 0", rx_busy); end
   endtask

   task automatic test_back_to_back;
      logic [7:0] exp [3] = '{8'hA3, 8'h00, 8'hFF};
      got.delete(); ferr_n = 0;
      for (int i = 0; i < 3; i++) send_frame(exp[i], 1'b1, -1);
      wait_clk(64);
      checks++; if (got.size() != 3) begin errors++; $display("FAIL b2b_count: got %0d want 3", got.size()); end
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (got.size() != 3 || got[i] !== exp[i]) begin
            errors++; $display("FAIL b2b_data%0d: got %h want %h", i, (got.size() > i) ? got[i] : 8'hxx, exp[i]);
         end
      end
      checks++; if (ferr_n != 0) begin errors++; $display("FAIL b2b_ferr: got %0d want 0", ferr_n); end
   endtask

   task automatic test_glitch;
      logic seen = 1'b0;
      got.delete(); ferr_n = 0;
      rx = 1'b0;
      repeat (64) begin @(negedge clk); if (rx_busy) seen = 1'b1; end
      rx = 1'b1;
      repeat (300) begin @(negedge clk); if (rx_busy) seen = 1'b1; end
      checks++; if (seen !== 1'b1) begin errors++; $display("FAIL glitch_busy_pulse: got %b want 1", seen); end
      checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_end: got %b want 0", rx_busy); end
      checks++; if (got.size() != 0) begin errors++; $display("FAIL glitch_done: got %0d want 0", got.size()); end
      checks++; if (ferr_n != 0) begin errors++; $display("FAIL glitch_ferr: got %0d want 0", ferr_n); end
      checks++; if (rx_data !== 8'hFF) begin errors++; $display("FAIL glitch_data: got %h want ff", rx_data); end
   endtask

   task automatic test_frame_error;
      got.delete(); ferr_n = 0;
      send_frame(8'h0F, 1'b0, -1);
      wait_clk(512);
      checks++; if (ferr_n != 1) begin errors++; $display("FAIL ferr_pulse: got %0d want 1", ferr_n); end
      checks++; if (got.size() != 0) begin errors++; $display("FAIL ferr_done: got %0d want 0", got.size()); end
      checks++; if (rx_data !== 8'hFF) begin errors++; $display("FAIL ferr_data: got %h want ff", rx_data); end
      send_frame(8'h3C, 1'b1, -1);
      wait_clk(64);
      checks++; if (got.size() != 1) begin errors++; $display("FAIL ferr_next_count: got %0d want 1", got.size()); end
      checks++; if (rx_data !== 8'h3C) begin errors++; $display("FAIL ferr_next_data: got %h want 3c", rx_data); end
   endtask

   task automatic test_mid_reset;
      logic [7:0] b = 8'h96;
      got.delete(); ferr_n = 0;
      rx = 1'b0;
      wait_clk(256);
      for (int i = 0; i < 3; i++) begin rx = b[i]; wait_clk(256); end
      rx = b[3];
      wait_clk(128);
      checks++; if (rx_busy !== 1'b1) begin errors++; $display("FAIL rst_busy_before: got %b want 1", rx_busy); end
      rst = 1'b1;
      #1;
      checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL rst_async_data: got %h want 00", rx_data); end
      checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL rst_async_busy: got %b want 0", rx_busy); end
      checks++; if (rx_done !== 1'b0) begin errors++; $display("FAIL rst_async_done: got %b want 0", rx_done); end
      checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL rst_async_ferr: got %b want 0", frame_err); end
      wait_clk(128);
      for (int i = 4; i < 8; i++) begin rx = b[i]; wait_clk(256); end
      rx = 1'b1;
      wait_clk(256);
      rst = 1'b0;
      wait_clk(64);
      checks++; if (got.size() != 0 || ferr_n != 0) begin errors++; $display("FAIL rst_strobe: got %0d/%0d want 0/0", got.size(), ferr_n); end
      send_frame(8'h3C, 1'b1, -1);
      wait_clk(64);
      checks++; if (rx_data !== 8'h3C) begin errors++; $display("FAIL rst_next_data: got %h want 3c", rx_data); end
      checks++; if (got.size() != 1) begin errors++; $display("FAIL rst_next_count: got %0d want 1", got.size()); end
   endtask

   task automatic test_freeze;
      got.delete(); ferr_n = 0;
      send_frame(8'hC5, 1'b1, 4);
      wait_clk(64);
      checks++; if (fz_busy !== 1'b1) begin errors++; $display("FAIL freeze_busy: got %b want 1", fz_busy); end
      checks++; if (fz_n != 0) begin errors++; $display("FAIL freeze_strobe: got %0d want 0", fz_n); end
      checks++; if (got.size() != 1) begin errors++; $display("FAIL freeze_count: got %0d want 1", got.size()); end
      checks++; if (rx_data !== 8'hC5) begin errors++; $display("FAIL freeze_data: got %h want c5", rx_data); end
      checks++; if (ferr_n != 0) begin errors++; $display("FAIL freeze_ferr: got %0d want 0", ferr_n); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_glitch();
      test_frame_error();
      test_mid_reset();
      test_freeze();
      checks++; if (both_n != 0) begin errors++; $display("FAIL strobe_overlap: got %0d want 0", both_n); end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
